// File: rtl/hd44780_cmd_sched.sv
// Two-requester round-robin scheduler for an HD44780 LCD in 4-bit mode.
// Each accepted byte goes out as two enable-strobed nibbles followed by a busy wait.
module hd44780_cmd_sched #(
    parameter int unsigned SHORT_WAIT = 13,
    parameter int unsigned LONG_WAIT  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_busy,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       grant_id,
    output logic       e,
    output logic       rs,
    output logic [3:0] db
);

    localparam logic [15:0] ShortW = 16'(SHORT_WAIT);
    localparam logic [15:0] LongW  = 16'(LONG_WAIT);

    typedef enum logic [2:0] {
        StIdle, StSetH, StEH, StHoldH, StSetL, StEL, StHoldL, StWait
    } state_e;

    state_e      state_q, state_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic [3:0]  db_q, db_d;
    logic        gid_q, gid_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cap_rs_q, cap_rs_d;
    logic [7:0]  data_q, data_d;

    logic        sel;
    logic        can_accept;
    logic        accept;
    logic        is_long;

    // Tie goes to whoever did not win last; a lone requester always wins.
    assign sel        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign can_accept = rst && (state_q == StIdle) && !init_busy;
    assign req0_ready = can_accept && req0_valid && !sel;
    assign req1_ready = can_accept && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;

    assign is_long  = !cap_rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    assign busy     = init_busy || (state_q != StIdle);
    assign grant_id = gid_q;
    assign e        = e_q;
    assign rs       = rs_q;
    assign db       = db_q;

    always_comb begin
        state_d  = state_q;
        e_d      = 1'b0;
        rs_d     = rs_q;
        db_d     = db_q;
        gid_d    = gid_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        cap_rs_d = cap_rs_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StSetH;
                    cap_rs_d = sel ? req1_rs : req0_rs;
                    data_d   = sel ? req1_data : req0_data;
                    rs_d     = sel ? req1_rs : req0_rs;
                    db_d     = sel ? req1_data[7:4] : req0_data[7:4];
                    gid_d    = sel;
                    last_d   = sel;
                end
            end
            StSetH: begin
                state_d = StEH;
                e_d     = 1'b1;
            end
            StEH:    state_d = StHoldH;
            StHoldH: begin
                state_d = StSetL;
                db_d    = data_q[3:0];
            end
            StSetL: begin
                state_d = StEL;
                e_d     = 1'b1;
            end
            StEL:    state_d = StHoldL;
            StHoldL: begin
                state_d = StWait;
                cnt_d   = is_long ? LongW : ShortW;
            end
            StWait: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            db_q     <= 4'h0;
            gid_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 16'd0;
            cap_rs_q <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            db_q     <= db_d;
            gid_q    <= gid_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            cap_rs_q <= cap_rs_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_hd44780_cmd_sched.sv
// Bench for hd44780_cmd_sched: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level timing model.
module tb_hd44780_cmd_sched;

    localparam int SW = 13;
    localparam int LW = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_busy = 1'b0;
    logic       req0_valid = 1'b0, req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, busy, grant_id, e, rs;
    logic [3:0] db;

    hd44780_cmd_sched #(.SHORT_WAIT(SW), .LONG_WAIT(LW)) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .busy(busy), .grant_id(grant_id), .e(e), .rs(rs), .db(db)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: a transfer accepted in cycle m_t0 occupies the bus until m_free.
    int         m_free = 0;
    int         m_t0 = -1;
    bit         m_last = 1'b1;
    bit         m_gid = 1'b0;
    bit         m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(output bit acc);
        bit         idle, can, sel, er0, er1, ee, ers;
        int         k;
        logic [3:0] edb;
        @(negedge clk);
        idle = (cyc >= m_free);
        can  = (rst === 1'b1) && idle && !init_busy;
        sel  = (req0_valid && req1_valid) ? !m_last : req1_valid;
        er0  = can && req0_valid && !sel;
        er1  = can && req1_valid && sel;
        k    = cyc - m_t0;
        if (m_t0 < 0) begin
            ee = 1'b0; edb = 4'h0; ers = 1'b0;
        end else begin
            ee  = (k == 2) || (k == 5);
            edb = (k <= 3) ? m_data[7:4] : m_data[3:0];
            ers = m_rs;
        end
        chk("ready0", 32'(req0_ready), 32'(er0));
        chk("ready1", 32'(req1_ready), 32'(er1));
        chk("busy", 32'(busy), 32'(init_busy || !idle));
        chk("e", 32'(e), 32'(ee));
        chk("db", 32'(db), 32'(edb));
        chk("rs", 32'(rs), 32'(ers));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        acc = er0 || er1;
        if (acc) begin
            m_t0   = cyc;
            m_rs   = sel ? req1_rs : req0_rs;
            m_data = sel ? req1_data : req0_data;
            m_gid  = sel;
            m_last = sel;
            m_free = cyc + 7 + ((!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? LW : SW);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic wait_accept(input string tag, input int bound);
        bit acc;
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step(acc);
            got = acc;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_e", 32'(e), 32'd0);
        chk("rst_db", 32'(db), 32'd0);
        chk("rst_rs", 32'(rs), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'(init_busy));
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        m_free = 0; m_t0 = -1; m_last = 1'b1; m_gid = 1'b0;
        repeat (2) @(posedge clk);
        cyc += 2;
        #1 rst = 1'b1;
    endtask

    initial begin
        bit acc;
        #2;
        req0_valid = 1'b1;
        do_reset();

        // Single data write 'A'
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        wait_accept("single_accept", 5);
        req0_valid = 1'b0;
        run(30);

        // Inputs changed right after accept must not leak into the transfer
        req0_valid = 1'b1; req0_data = 8'h41;
        wait_accept("stable_accept", 5);
        req0_data = 8'hFF; req0_valid = 1'b0;
        run(4);
        chk("stable_low_nibble", 32'(db), 32'h1);
        run(20);

        // Long (clear) then short (rs=0, 0x00)
        req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
        wait_accept("long_accept", 5);
        req1_valid = 1'b0;
        run(7 + LW - 2);
        chk("long_still_busy", 32'(busy), 32'd1);
        run(4);
        req1_valid = 1'b1; req1_data = 8'h00;
        wait_accept("short_accept", 5);
        req1_valid = 1'b0;
        run(25);

        // Init gating
        init_busy = 1'b1; req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h5C;
        run(100);
        init_busy = 1'b0;
        step(acc);
        chk("init_release_accept", 32'(acc), 32'd1);
        req0_valid = 1'b0;
        run(25);

        // Contention from reset: expect 0,1,0,1
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h30; req1_data = 8'h31;
        req1_rs = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_accept("contention_accept", 30);
            chk("contention_order", 32'(grant_id), 32'(i % 2));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(25);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            init_busy  = ($urandom_range(0, 9) == 0);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_rs    = 1'($urandom_range(0, 1));
            req1_rs    = 1'($urandom_range(0, 1));
            req0_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                     : 8'($urandom_range(0, 255));
            req1_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                     : 8'($urandom_range(0, 255));
            step(acc);
        end
        init_busy = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        run(520);

        // Reset during E_L, then a pending req1 is resent from scratch
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h5A;
        wait_accept("midreset_accept", 5);
        req0_valid = 1'b0;
        run(4);
        chk("midreset_e_high", 32'(e), 32'd1);
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h37;
        do_reset();
        wait_accept("midreset_resend", 5);
        chk("midreset_gid", 32'(grant_id), 32'd1);
        chk("midreset_hi", 32'(db), 32'h3);
        req1_valid = 1'b0;
        run(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
